burst_ram_initiator: RTL
========================

# burst_ram_initiator

Line-level initiator for the burst RAM interface. It accepts one cache-line read or write request from a client, issues a single burst command to the burst RAM, and streams `BURST_COUNT` 64-bit beats out or collects them in. For a read, it returns the assembled line with a one-cycle response strobe. It sits between the cache/CPU side and the burst RAM and is the only block that drives the RAM's command port.

## Interface
Parameters:
- `BURST_COUNT`, default 4: beats per burst; power of two, at least 2.
- `ADDR_WIDTH`, default 4: width of the RAM word address (one word is 8 bytes).
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles from read command issue to the first `rd_data_valid`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  1  client request strobe
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = line write, 0 = line read
- `req_addr`  in  ADDR_WIDTH  word address; low log2(BURST_COUNT) bits are forced to 0
- `req_wr_line`  in  64*BURST_COUNT  write data; beat i is `[64*i +: 64]`
- `req_wr_mask`  in  8*BURST_COUNT  byte masks, 1 = byte not written; beat i is `[8*i +: 8]`
- `resp_valid`  out  1  one-cycle completion strobe
- `resp_error`  out  1  qualified by `resp_valid`; 1 = read timeout
- `rd_line`  out  64*BURST_COUNT  assembled read line; held until the next read completes
- `cmd`  out  1  to RAM: 0 = read, 1 = write
- `cmd_en`  out  1  to RAM: command strobe
- `addr`  out  ADDR_WIDTH  to RAM
- `wr_data`  out  64  to RAM
- `data_mask`  out  8  to RAM
- `rd_data`  in  64  from RAM
- `rd_data_valid`  in  1  from RAM
- `busy`  in  1  from RAM

## Operation
State machine: IDLE, ISSUE, RD_WAIT, RD_BURST, WR_BURST, RESP.

- **IDLE**
  - On accept, latch `req_write`, the aligned address, `req_wr_line` and `req_wr_mask`, then go to ISSUE.
- **ISSUE**
  - Wait while `busy` is high.
  - On the first cycle with `busy` low, drive `cmd_en`=1 and `cmd`=`req_write` with the latched `addr`.
  - For a write, also drive beat 0 on `wr_data`/`data_mask`. Next state is WR_BURST with beat counter 1, or RD_WAIT with the timeout counter cleared.
- **WR_BURST**
  - `cmd_en`=0. Drive beats 1..BURST_COUNT-1 on consecutive cycles with no gaps.
  - After the last beat, go to RESP.
- **RD_WAIT**
  - The timeout counter increments each cycle.
  - When `rd_data_valid`=1, capture `rd_data` into beat 0 and go to RD_BURST with beat counter 1.
  - If the counter reaches `TIMEOUT_CYCLES` first, go to RESP with the error flag set. `rd_line` is left unchanged.
- **RD_BURST**
  - On each cycle with `rd_data_valid`=1, capture beat n into `rd_line[64*n +: 64]` and increment n.
  - Cycles with `rd_data_valid`=0 mid-burst are tolerated: hold and do not time out.
  - After beat BURST_COUNT-1 is captured, go to RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle; `resp_error` equals the error flag. Then go to IDLE.
- Requests presented while `req_ready`=0 are ignored and not queued.
- `rd_data_valid` seen in IDLE, ISSUE or WR_BURST is ignored.
- Counter widths: clog2(BURST_COUNT) bits for beats and clog2(TIMEOUT_CYCLES+1) bits for the timeout. Neither counter wraps.

## Timing
- Reset values: state IDLE (`req_ready`=1). `cmd`, `cmd_en`, `addr`, `wr_data`, `data_mask`, `resp_valid`, `resp_error` and `rd_line` are all 0.
- Assertion of `rst_n`=0 mid-operation aborts immediately: the block returns to IDLE, all outputs take their reset values, and no response is generated.
- All RAM-side and response outputs are registered. `req_ready` is decoded from the state register.
- The earliest `cmd_en` is the cycle after the accept edge.
- Write latency, accept to `resp_valid` with `busy` low: 1 (ISSUE) + BURST_COUNT-1 (WR_BURST) + 1 = BURST_COUNT+1 cycles.
- Read latency: RAM latency + BURST_COUNT + 1 cycles, with no fixed-latency assumption.
- `cmd_en` is high for exactly one cycle per request and never while `busy` is high.
- `rd_line` updates in the same cycle `resp_valid` rises for a successful read.

## Test plan
- **Read line 0:** RAM model loaded with RAM.mem (4-cycle latency, 4 beats). Read `req_addr`=0 must give `rd_line` = {7D4E9F2C1B6A3D8F, A1C3F7E2D5B8A9C4, 9D8E2F17AB4C3E6F, 3F5A2E14B7C6A980} (MSB beat first), with `resp_error`=0 and exactly one `cmd_en` pulse with `cmd`=0.
- **Read with unaligned address:** `req_addr`=5 must drive `addr`=4 and give `rd_line` = {D4E7F2C5B8A3D6E9, F8E9D2C3B4A5F6E7, E1A7D0B5C8F3E6A9, 6C4B9A8D2F5E3C7A}.
- **Write then read back:** write addr 8 with beats 1111..., 2222..., 3333..., 4444... and mask 0 must produce `resp_valid` 5 cycles after accept. A following read of addr 8 must return the same 4 beats.
- **Byte mask:** write addr 0 with beat 0 mask 8'h0F and data FFFF_FFFF_FFFF_FFFF. Read-back beat 0 must be FFFFFFFFB7C6A980; beats 1-3 must be unchanged.
- **Busy and timeout:** hold `busy`=1 for 10 cycles after accept; `cmd_en` must stay 0 until the cycle after `busy` falls. With a stubbed RAM that never asserts `rd_data_valid`, a read must give `resp_valid`=1 and `resp_error`=1 exactly `TIMEOUT_CYCLES` cycles after `cmd_en`, with `rd_line` unchanged.
- **Reset mid-burst:** pull `rst_n` low during RD_BURST. `resp_valid` must never pulse, `req_ready`=1 and `cmd_en`=0 while in reset, and the next read must complete normally.

Source files
------------

// File: rtl/burst_ram_initiator.sv
// Cache-line initiator for the burst RAM: turns one line read/write request into a
// single burst command, streams write beats out or gathers read beats in, then responds.
module burst_ram_initiator #(
  parameter int BURST_COUNT    = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [64*BURST_COUNT-1:0]  req_wr_line,
  input  logic [8*BURST_COUNT-1:0]   req_wr_mask,
  output logic                       resp_valid,
  output logic                       resp_error,
  output logic [64*BURST_COUNT-1:0]  rd_line,
  output logic                       cmd,
  output logic                       cmd_en,
  output logic [ADDR_WIDTH-1:0]      addr,
  output logic [63:0]                wr_data,
  output logic [7:0]                 data_mask,
  input  logic [63:0]                rd_data,
  input  logic                       rd_data_valid,
  input  logic                       busy
);

  localparam int BEAT_W = $clog2(BURST_COUNT);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BURST_COUNT - 1);
  // The RESP cycle is the last of the TIMEOUT_CYCLES counted from cmd_en.
  localparam logic [TO_W-1:0]       TO_LAST    = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    RD_WAIT  = 3'd2,
    RD_BURST = 3'd3,
    WR_BURST = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t                  state_r;
  logic                    write_r;
  logic                    err_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [BEAT_W-1:0]       beat_r;
  logic [TO_W-1:0]         tmo_r;
  logic [63:0]             line_r [BURST_COUNT];
  logic [7:0]              mask_r [BURST_COUNT];

  assign req_ready = (state_r == IDLE);

  // Request/burst sequencer with all RAM-side and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      write_r    <= 1'b0;
      err_r      <= 1'b0;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      beat_r     <= {BEAT_W{1'b0}};
      tmo_r      <= {TO_W{1'b0}};
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      rd_line    <= {(64*BURST_COUNT){1'b0}};
      cmd        <= 1'b0;
      cmd_en     <= 1'b0;
      addr       <= {ADDR_WIDTH{1'b0}};
      wr_data    <= 64'd0;
      data_mask  <= 8'd0;
      for (int i = 0; i < BURST_COUNT; i++) begin
        line_r[i] <= 64'd0;
        mask_r[i] <= 8'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          if (req_valid) begin
            write_r <= req_write;
            addr_r  <= req_addr & ALIGN_MASK;
            err_r   <= 1'b0;
            for (int i = 0; i < BURST_COUNT; i++) begin
              line_r[i] <= req_wr_line[64*i +: 64];
              mask_r[i] <= req_wr_mask[8*i +: 8];
            end
            state_r <= ISSUE;
          end
        end
        ISSUE: begin
          if (!busy) begin
            cmd_en <= 1'b1;
            cmd    <= write_r;
            addr   <= addr_r;
            if (write_r) begin
              wr_data   <= line_r[0];
              data_mask <= mask_r[0];
              beat_r    <= BEAT_W'(1);
              state_r   <= WR_BURST;
            end else begin
              tmo_r   <= {TO_W{1'b0}};
              state_r <= RD_WAIT;
            end
          end
        end
        WR_BURST: begin
          cmd_en    <= 1'b0;
          wr_data   <= line_r[beat_r];
          data_mask <= mask_r[beat_r];
          if (beat_r == LAST_BEAT) begin
            state_r <= RESP;
          end else begin
            beat_r <= beat_r + BEAT_W'(1);
          end
        end
        RD_WAIT: begin
          cmd_en <= 1'b0;
          if (rd_data_valid) begin
            line_r[0] <= rd_data;
            beat_r    <= BEAT_W'(1);
            state_r   <= RD_BURST;
          end else if (tmo_r == TO_LAST) begin
            err_r   <= 1'b1;
            state_r <= RESP;
          end else begin
            tmo_r <= tmo_r + TO_W'(1);
          end
        end
        RD_BURST: begin
          // Gaps in rd_data_valid simply stall here; no timeout once data started.
          if (rd_data_valid) begin
            line_r[beat_r] <= rd_data;
            if (beat_r == LAST_BEAT) begin
              state_r <= RESP;
            end else begin
              beat_r <= beat_r + BEAT_W'(1);
            end
          end
        end
        RESP: begin
          resp_valid <= 1'b1;
          resp_error <= err_r;
          if (!err_r && !write_r) begin
            for (int i = 0; i < BURST_COUNT; i++) begin
              rd_line[64*i +: 64] <= line_r[i];
            end
          end
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
